// File: rtl/add_seq.sv
// rtl/add_seq.sv - nibble-serial adder reusing one 4-bit ripple stage per cycle
// Optional subtract support (input port sub) is enabled by defining ADD_SEQ_SUB_EN.
module add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 carryin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                 sub,
`endif
    input  logic [4*NIBBLES-1:0] X,
    input  logic [4*NIBBLES-1:0] Y,
    output logic [4*NIBBLES-1:0] S,
    output logic                 carryout,
    output logic                 busy,
    output logic                 done
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [W-1:0]  x_q;
    logic [W-1:0]  y_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_d;
    logic [KW-1:0] k_q;
    logic          carry_q;
    logic          carry_init;
    logic [W-1:0]  s_q;
    logic          cout_q;
    logic          busy_q;
    logic          done_q;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    sum_nib;
    logic [4:0]    c;

`ifdef ADD_SEQ_SUB_EN
    logic          sub_q;

    // Subtraction is X + ~Y + 1, so the stage carry-in replaces carryin.
    assign carry_init = sub ? 1'b1 : carryin;
    assign b_nib      = sub_q ? ~y_q[k_q*4 +: 4] : y_q[k_q*4 +: 4];
`else
    assign carry_init = carryin;
    assign b_nib      = y_q[k_q*4 +: 4];
`endif

    assign a_nib = x_q[k_q*4 +: 4];

    always_comb begin
        c[0]    = carry_q;
        sum_nib = '0;
        for (int i = 0; i < 4; i++) begin
            sum_nib[i] = a_nib[i] ^ b_nib[i] ^ c[i];
            c[i+1]     = (a_nib[i] & b_nib[i]) | (c[i] & (a_nib[i] ^ b_nib[i]));
        end
    end

    always_comb begin
        acc_d             = acc_q;
        acc_d[k_q*4 +: 4] = sum_nib;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= X;
                        y_q     <= Y;
                        carry_q <= carry_init;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef ADD_SEQ_SUB_EN
                        sub_q   <= sub;
`endif
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= c[4];
                    if (k_q == K_LAST) begin
                        // acc_d already holds the final nibble, so S sees the full result now.
                        s_q     <= acc_d;
                        cout_q  <= c[4];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        k_q     <= '0;
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign S        = s_q;
    assign carryout = cout_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_add_seq.sv
// tb/tb_add_seq.sv - randomized self-checking bench for add_seq (NIBBLES=4 and NIBBLES=1)
module tb_add_seq;
    logic        clk;
    logic        resetn;
    logic        start;
    logic        carryin;
    logic [15:0] X;
    logic [15:0] Y;
    logic [15:0] S;
    logic        carryout;
    logic        busy;
    logic        done;

    logic        start1;
    logic        cin1;
    logic [3:0]  x1;
    logic [3:0]  y1;
    logic [3:0]  s1;
    logic        co1;
    logic        busy1;
    logic        done1;
`ifdef ADD_SEQ_SUB_EN
    logic        sub;
    logic        sub1;
`endif

    int          total;
    int          bad;
    logic [15:0] prev_s;
    logic        prev_c;

    add_seq #(.NIBBLES(4)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .carryin(carryin),
`ifdef ADD_SEQ_SUB_EN
        .sub(sub),
`endif
        .X(X), .Y(Y), .S(S), .carryout(carryout), .busy(busy), .done(done)
    );

    add_seq #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .carryin(cin1),
`ifdef ADD_SEQ_SUB_EN
        .sub(sub1),
`endif
        .X(x1), .Y(y1), .S(s1), .carryout(co1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Result as plain integer arithmetic: low 4n bits are S, bit 4n is carryout.
    function automatic longint ref_model(input int n, input longint x, input longint y,
                                         input bit ci, input bit sb);
        longint m;
        m = (longint'(1) << (4 * n)) - 1;
        if (sb)
            return ((x - y) & m) | ((x >= y) ? (m + 1) : 64'd0);
        return x + y + longint'(ci);
    endfunction

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input bit ci, input bit sb,
                          input bit inject, input bit rel, input string tag);
        longint exp_v;
        int     cyc;
        int     busy_n;
        bit     held;
        exp_v = ref_model(4, longint'(x), longint'(y), ci, sb);
        @(negedge clk);
        if (rel) resetn = 1'b1;
        start = 1'b1; X = x; Y = y; carryin = ci;
`ifdef ADD_SEQ_SUB_EN
        sub = sb;
`endif
        @(posedge clk); #1;
        check({tag, "/busy_e0"}, 32'(busy), 32'd1);
        start = 1'b0; X = 16'($urandom); Y = 16'($urandom); carryin = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
        sub = 1'($urandom);
`endif
        cyc = 0; busy_n = int'(busy); held = 1'b1;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) busy_n++;
            if (!done && (S !== prev_s || carryout !== prev_c)) held = 1'b0;
            start = inject && (cyc == 1);
            if (start) begin X = 16'($urandom); Y = 16'($urandom); end
        end
        check({tag, "/latency"}, 32'(cyc), 32'd4);
        check({tag, "/busy_cycles"}, 32'(busy_n), 32'd4);
        check({tag, "/hold"}, 32'(held), 32'd1);
        check({tag, "/S"}, 32'(S), 32'(exp_v[15:0]));
        check({tag, "/carryout"}, 32'(carryout), 32'(exp_v[16]));
        if (inject) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
        check({tag, "/idle"}, 32'(busy), 32'd0);
        prev_s = exp_v[15:0];
        prev_c = exp_v[16];
    endtask

    task automatic run1(input logic [3:0] x, input logic [3:0] y, input bit ci, input bit sb,
                        input string tag);
        longint exp_v;
        int     cyc;
        exp_v = ref_model(1, longint'(x), longint'(y), ci, sb);
        @(negedge clk);
        start1 = 1'b1; x1 = x; y1 = y; cin1 = ci;
`ifdef ADD_SEQ_SUB_EN
        sub1 = sb;
`endif
        @(posedge clk); #1;
        check({tag, "/busy_e0"}, 32'(busy1), 32'd1);
        start1 = 1'b0; x1 = 4'($urandom); y1 = 4'($urandom);
        cyc = 0;
        while (!done1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "/latency"}, 32'(cyc), 32'd1);
        check({tag, "/S"}, 32'(s1), 32'(exp_v[3:0]));
        check({tag, "/carryout"}, 32'(co1), 32'(exp_v[4]));
        @(posedge clk); #1;
        check({tag, "/done_pulse"}, 32'(done1), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_done;
        bit sb;
        logic [15:0] rx;
        logic [15:0] ry;
        total = 0; bad = 0;
        resetn = 1'b0; start = 1'b0; carryin = 1'b0; X = '0; Y = '0;
        start1 = 1'b0; cin1 = 1'b0; x1 = '0; y1 = '0;
`ifdef ADD_SEQ_SUB_EN
        sub = 1'b0; sub1 = 1'b0;
`endif
        prev_s = '0; prev_c = 1'b0; sb = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst/S", 32'(S), 32'd0);
        check("rst/carryout", 32'(carryout), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/S1", 32'(s1), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0, "add_basic");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, "carry_chain");
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "cin_ignore_start");

        @(negedge clk);
        start = 1'b1; X = 16'h00FF; Y = 16'h0001; carryin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("abort/S", 32'(S), 32'd0);
        check("abort/carryout", 32'(carryout), 32'd0);
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/done", 32'(done), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort/no_done", 32'(saw_done), 32'd0);
        prev_s = '0; prev_c = 1'b0;
        run_op(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1, "after_reset");

`ifdef ADD_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0, "sub_borrow");
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0, "sub_noborrow");
`endif

        for (int i = 0; i < 30; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (i % 5 == 0) rx = 16'hFFFF;
            if (i % 7 == 0) ry = 16'hFFFF - rx;
`ifdef ADD_SEQ_SUB_EN
            sb = 1'($urandom);
`endif
            run_op(rx, ry, 1'($urandom), sb, 1'($urandom), 1'b0, $sformatf("rand%0d", i));
        end

        run1(4'hF, 4'h0, 1'b1, 1'b0, "n1_carry");
        for (int i = 0; i < 12; i++) begin
`ifdef ADD_SEQ_SUB_EN
            sb = 1'($urandom);
`endif
            run1(4'($urandom), 4'($urandom), 1'($urandom), sb, $sformatf("n1_rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
